// File: rtl/rtc_shadow_bank.sv
// Double-buffered RTC register capture: bus data phases land in a staging bank and are
// copied atomically to the visible bank at end of burst. Optional macro: RTC_SHADOW_BCD_CHECK_EN.
module rtc_shadow_bank #(
  parameter int unsigned       DATA_W = 8,
  parameter int unsigned       ADDR_W = 8,
  parameter int unsigned       NREG_A = 8,
  parameter logic [ADDR_W-1:0] BASE_A = ADDR_W'('h21),
  parameter int unsigned       NREG_B = 3,
  parameter logic [ADDR_W-1:0] BASE_B = ADDR_W'('h41)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_W-1:0]                 address,
  input  logic [DATA_W-1:0]                 data_vga,
  input  logic                              AoD,
  input  logic                              wr_valid,
  input  logic                              burst_end,
  output logic [(NREG_A+NREG_B)*DATA_W-1:0] datos,
  output logic [NREG_A+NREG_B-1:0]          dirty,
  output logic                              commit_pulse,
  output logic                              busy,
  output logic                              bcd_err
);

  localparam int unsigned NREG  = NREG_A + NREG_B;
  localparam int unsigned OFF_W = ADDR_W + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_COMMIT  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NREG-1:0] dirty_q, dirty_d;
  logic            commit_pulse_q, commit_pulse_d;
  logic            busy_q, busy_d;

  logic [OFF_W-1:0] off_a, off_b;
  logic             in_a, in_b, data_hit, bcd_ok, wr_acc;
  logic [NREG-1:0]  wr_sel;

  // Window decode; the extra top bit catches addresses below the window base.
  always_comb begin
    off_a    = {1'b0, address} - {1'b0, BASE_A};
    off_b    = {1'b0, address} - {1'b0, BASE_B};
    in_a     = !off_a[OFF_W-1] && (off_a < OFF_W'(NREG_A));
    in_b     = !off_b[OFF_W-1] && (off_b < OFF_W'(NREG_B));
    data_hit = wr_valid && !AoD && (in_a || in_b);
    wr_acc   = data_hit && bcd_ok;
  end

  for (genvar g = 0; g < NREG_A; g++) begin : g_sel_a
    assign wr_sel[g] = in_a && (off_a == OFF_W'(g));
  end

  // Window A has priority where the two windows overlap.
  for (genvar g = 0; g < NREG_B; g++) begin : g_sel_b
    assign wr_sel[NREG_A+g] = !in_a && in_b && (off_b == OFF_W'(g));
  end

`ifdef RTC_SHADOW_BCD_CHECK_EN
  localparam int unsigned NNIB = DATA_W / 4;

  logic [NNIB-1:0] nib_bad;
  logic            bcd_err_q, bcd_err_d;

  for (genvar g = 0; g < NNIB; g++) begin : g_nib
    assign nib_bad[g] = data_vga[4*g +: 4] > 4'd9;
  end

  always_comb begin
    bcd_ok    = ~|nib_bad;
    bcd_err_d = bcd_err_q | (data_hit && !bcd_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcd_err_q <= 1'b0;
    end else begin
      bcd_err_q <= bcd_err_d;
    end
  end

  assign bcd_err = bcd_err_q;
`else
  assign bcd_ok  = 1'b1;
  assign bcd_err = 1'b0;
`endif

  // Next-state, dirty tracking and registered status outputs.
  always_comb begin
    state_d        = state_q;
    dirty_d        = dirty_q;
    commit_pulse_d = 1'b0;
    busy_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (wr_acc) begin
          state_d = burst_end ? S_COMMIT : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (burst_end) begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        dirty_d        = '0;
        commit_pulse_d = 1'b1;
        state_d        = wr_acc ? S_COLLECT : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A write in the commit cycle re-marks its entry after the clear.
    if (wr_acc) begin
      dirty_d = dirty_d | wr_sel;
    end

    busy_d = (state_d == S_COMMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      dirty_q        <= '0;
      commit_pulse_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      dirty_q        <= dirty_d;
      commit_pulse_q <= commit_pulse_d;
      busy_q         <= busy_d;
    end
  end

  // Per-entry staging and visible registers; commit copies the pre-edge staging value.
  for (genvar g = 0; g < NREG; g++) begin : g_ent
    logic [DATA_W-1:0] stg_q, stg_d;
    logic [DATA_W-1:0] vis_q, vis_d;

    always_comb begin
      stg_d = stg_q;
      vis_d = vis_q;
      if (wr_acc && wr_sel[g]) begin
        stg_d = data_vga;
      end
      if ((state_q == S_COMMIT) && dirty_q[g]) begin
        vis_d = stg_q;
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stg_q <= '0;
        vis_q <= '0;
      end else begin
        stg_q <= stg_d;
        vis_q <= vis_d;
      end
    end

    assign datos[g*DATA_W +: DATA_W] = vis_q;
  end

  assign dirty        = dirty_q;
  assign commit_pulse = commit_pulse_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_rtc_shadow_bank.sv
// Directed plus randomized bench for rtc_shadow_bank against an array-based shadow model.
module tb_rtc_shadow_bank;

  localparam int unsigned NA = 8;
  localparam int unsigned NB = 3;
  localparam int unsigned N  = NA + NB;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     address;
  logic [7:0]     data_vga;
  logic           AoD;
  logic           wr_valid;
  logic           burst_end;
  logic [N*8-1:0] datos;
  logic [N-1:0]   dirty;
  logic           commit_pulse;
  logic           busy;
  logic           bcd_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] m_stg [N];
  logic [7:0] m_vis [N];
  logic [N-1:0] m_dirty;
  bit m_collect, m_commit, m_pulse, m_bcd;

  rtc_shadow_bank dut (
    .clk(clk), .reset(reset), .address(address), .data_vga(data_vga), .AoD(AoD),
    .wr_valid(wr_valid), .burst_end(burst_end), .datos(datos), .dirty(dirty),
    .commit_pulse(commit_pulse), .busy(busy), .bcd_err(bcd_err)
  );

  always #5 clk = ~clk;

  function automatic int map_idx(input logic [7:0] a);
    if (a >= 8'h21 && a <= 8'h28) return int'(a) - 'h21;
    if (a >= 8'h41 && a <= 8'h43) return NA + int'(a) - 'h41;
    return -1;
  endfunction

  function automatic bit bcd_valid(input logic [7:0] d);
    return (d[3:0] <= 4'd9) && (d[7:4] <= 4'd9);
  endfunction

  function automatic logic [N*8-1:0] model_datos();
    logic [N*8-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*8 +: 8] = m_vis[i];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk($sformatf("%s.datos", tag), 128'(datos), 128'(model_datos()));
    chk($sformatf("%s.dirty", tag), 128'(dirty), 128'(m_dirty));
    chk($sformatf("%s.pulse", tag), 128'(commit_pulse), 128'(m_pulse));
    chk($sformatf("%s.busy", tag), 128'(busy), 128'(m_commit));
    chk($sformatf("%s.bcd", tag), 128'(bcd_err), 128'(m_bcd));
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_stg[i] = 8'h00;
      m_vis[i] = 8'h00;
    end
    m_dirty = '0;
    m_collect = 1'b0;
    m_commit = 1'b0;
    m_pulse = 1'b0;
    m_bcd = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #2;
    model_clear();
    check_all(tag);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One bus cycle: drive, clock, advance the model, then compare.
  task automatic step(input logic [7:0] a, input logic [7:0] d, input bit aod,
                      input bit wv, input bit be, input string tag);
    int idx;
    bit acc, do_c;
    address = a; data_vga = d; AoD = aod; wr_valid = wv; burst_end = be;
    @(posedge clk);
    idx = map_idx(a);
    acc = wv && !aod && (idx >= 0);
`ifdef RTC_SHADOW_BCD_CHECK_EN
    if (acc && !bcd_valid(d)) begin
      acc = 1'b0;
      m_bcd = 1'b1;
    end
`endif
    do_c = m_commit;
    if (do_c) begin
      for (int i = 0; i < N; i++) if (m_dirty[i]) m_vis[i] = m_stg[i];
      m_dirty = '0;
    end
    if (acc) begin
      m_stg[idx] = d;
      m_dirty[idx] = 1'b1;
    end
    if (do_c) begin
      m_commit = 1'b0;
      m_collect = acc;
    end else if (m_collect) begin
      if (be) begin
        m_commit = 1'b1;
        m_collect = 1'b0;
      end
    end else if (acc) begin
      m_commit = be;
      m_collect = !be;
    end
    m_pulse = do_c;
    #1;
    check_all(tag);
    wr_valid = 1'b0;
    burst_end = 1'b0;
  endtask

  initial begin
    logic [7:0] a, d;
    logic [7:0] bnd [4];
    bnd[0] = 8'h20; bnd[1] = 8'h29; bnd[2] = 8'h40; bnd[3] = 8'h44;
    address = '0; data_vga = '0; AoD = 1'b0; wr_valid = 1'b0; burst_end = 1'b0;
    reset = 1'b1;
    do_reset("por");
    chk("por_datos_zero", 128'(datos), 128'h0);

    // Two window-A writes then burst_end
    step(8'h21, 8'h59, 0, 1, 0, "t1_w0");
    step(8'h28, 8'h12, 0, 1, 0, "t1_w7");
    step(8'h00, 8'h00, 0, 0, 1, "t1_be");
    chk("t1_busy", 128'(busy), 128'h1);
    step(8'h00, 8'h00, 0, 0, 0, "t1_commit");
    chk("t1_pulse", 128'(commit_pulse), 128'h1);
    chk("t1_lo", 128'(datos[7:0]), 128'h59);
    chk("t1_hi", 128'(datos[63:56]), 128'h12);
    chk("t1_rest", 128'(datos[55:8]), 128'h0);
    step(8'h00, 8'h00, 0, 0, 0, "t1_after");
    chk("t1_pulse_once", 128'(commit_pulse), 128'h0);

    // Address phase and out-of-window data are ignored
    step(8'h42, 8'h30, 1, 1, 0, "t2_aod");
    step(8'h30, 8'h77, 0, 1, 0, "t2_oow");
    step(8'h00, 8'h00, 0, 0, 1, "t2_be");
    step(8'h00, 8'h00, 0, 0, 0, "t2_idle");
    chk("t2_nopulse", 128'(commit_pulse), 128'h0);
    chk("t2_notbusy", 128'(busy), 128'h0);

    // Write coincident with burst_end is in the same commit
    step(8'h41, 8'h05, 0, 1, 1, "t3_wbe");
    step(8'h00, 8'h00, 0, 0, 0, "t3_commit");
    chk("t3_idx8", 128'(datos[71:64]), 128'h05);
    chk("t3_pulse", 128'(commit_pulse), 128'h1);

    // Write during the commit cycle
    step(8'h23, 8'h20, 0, 1, 0, "t4_pre");
    step(8'h00, 8'h00, 0, 0, 1, "t4_be");
    step(8'h23, 8'h44, 0, 1, 0, "t4_wcommit");
    chk("t4_old", 128'(datos[23:16]), 128'h20);
    chk("t4_dirty2", 128'(dirty[2]), 128'h1);
    step(8'h00, 8'h00, 0, 0, 1, "t4_be2");
    step(8'h00, 8'h00, 0, 0, 0, "t4_commit2");
    chk("t4_new", 128'(datos[23:16]), 128'h44);

    // Reset in the middle of a commit
    step(8'h21, 8'h11, 0, 1, 0, "t5_w");
    step(8'h00, 8'h00, 0, 0, 1, "t5_be");
    do_reset("t5_rst");
    chk("t5_zero", 128'(datos), 128'h0);
    step(8'h00, 8'h00, 0, 0, 1, "t5_be_after");
    step(8'h00, 8'h00, 0, 0, 0, "t5_idle");
    chk("t5_nopulse", 128'(commit_pulse), 128'h0);

`ifdef RTC_SHADOW_BCD_CHECK_EN
    step(8'h22, 8'h3A, 0, 1, 0, "t6_bad");
    step(8'h00, 8'h00, 0, 0, 1, "t6_be");
    step(8'h00, 8'h00, 0, 0, 0, "t6_idle");
    chk("t6_err", 128'(bcd_err), 128'h1);
    chk("t6_entry1", 128'(datos[15:8]), 128'h00);
    chk("t6_nopulse", 128'(commit_pulse), 128'h0);
`endif

    // Randomized traffic with boundary addresses and a reset midway
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: a = 8'h21 + 8'($urandom_range(0, 7));
        1: a = 8'h41 + 8'($urandom_range(0, 2));
        2: a = 8'($urandom);
        default: a = bnd[$urandom_range(0, 3)];
      endcase
      d = 8'($urandom);
      if (i == 200) do_reset("rnd_rst");
      step(a, d, $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0, $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rtc_shadow_bank.md
# rtc_shadow_bank

Parametrised, double-buffered capture bank for RTC register values read back over the RTC bus. Holds two address windows: clock/date, default 8 registers at 0x21, and timer, default 3 registers at 0x41. Data phases are captured into a staging bank. Staged values are committed atomically to the visible bank at end of burst, so the VGA text renderer never shows a half-updated time. It sits between the RTC read sequencer and the VGA character generator.

## Interface
Parameters:
- DATA_W, 8, register width
- ADDR_W, 8, bus address width
- NREG_A, 8, registers in window A (1..16)
- BASE_A, 8'h21, first address of window A
- NREG_B, 3, registers in window B (1..16)
- BASE_B, 8'h41, first address of window B

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  ADDR_W  current bus address
- data_vga  in  DATA_W  bus data
- AoD  in  1  1 = address phase, 0 = data phase
- wr_valid  in  1  data_vga/address valid this cycle
- burst_end  in  1  one-cycle pulse, read burst complete
- datos  out  (NREG_A+NREG_B)*DATA_W  visible bank; index 0 = BASE_A in LSBs, window B follows window A
- dirty  out  NREG_A+NREG_B  staged-but-uncommitted mask
- commit_pulse  out  1  one cycle when visible bank changed
- busy  out  1  high in COMMIT state
- bcd_err  out  1  sticky invalid-BCD flag (see Configuration)

## Operation
- Write accept: wr_valid && !AoD && address in [BASE_A, BASE_A+NREG_A-1] or [BASE_B, BASE_B+NREG_B-1].
  - Index = address-BASE_A, or NREG_A+(address-BASE_B).
  - Overlapping windows: window A wins.
  - Out-of-window addresses and AoD=1 cycles are ignored.
- Accepted write: staging[idx] <= data_vga, dirty[idx] <= 1. Last write to the same index wins.
- FSM: IDLE, COLLECT, COMMIT.
  - IDLE: first accepted write -> COLLECT. burst_end with dirty==0 is ignored (no pulse).
  - COLLECT: burst_end -> COMMIT. Writes keep landing.
  - COMMIT (exactly 1 cycle): every dirty entry is copied to the visible bank; clean entries are untouched. Dirty is cleared, commit_pulse is registered high, next state is IDLE.
- A write during COMMIT lands in staging and sets its dirty bit; the set overrides the clear. The visible bank gets the pre-write staging value. Next state is COLLECT instead of IDLE.
- A write in the same cycle as burst_end (COLLECT) is included in that commit.
- burst_end while in COMMIT is ignored.
- Reset (any time, including mid-COMMIT): staging, visible bank, dirty, bcd_err, commit_pulse and busy all go to 0; state goes to IDLE.

## Timing
- Staging/dirty update: the edge that samples the accepted write.
- burst_end sampled at edge N, COLLECT -> COMMIT: busy is high during cycle N..N+1.
  - At edge N+1, datos is updated and commit_pulse goes high for exactly one cycle, coincident with the new datos.
  - dirty reads 0 after edge N+1, unless a write occurred during COMMIT.
- Minimum burst_end spacing is 2 cycles; a closer pulse falls in COMMIT and is ignored.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- RTC_SHADOW_BCD_CHECK_EN defined:
  - A data phase with either nibble > 9 is not written.
  - Its dirty bit is not set.
  - bcd_err sets and stays set until reset.
- Undefined: all data is accepted unchecked; bcd_err is tied 0.

## Test plan
- Reset, then write 0x21<-0x59, 0x28<-0x12, then burst_end: datos[7:0]=0x59 and datos[63:56]=0x12 appear with commit_pulse at burst_end edge+1; all other entries remain 0.
- Write 0x42<-0x30 with AoD=1, then address 0x30 with AoD=0, then burst_end: no change, no commit_pulse, FSM stays in IDLE.
- Write 0x41<-0x05 in the same cycle as burst_end: committed at the following edge (index 8 = 0x05).
- Write 0x23<-0x44 during the COMMIT cycle: visible entry 2 keeps its old value; dirty[2]=1; state goes to COLLECT; the next burst_end commits 0x44.
- Assert reset mid-COMMIT after staging 0x21<-0x11: all outputs are 0 and a later burst_end gives no pulse.
- With RTC_SHADOW_BCD_CHECK_EN, write 0x22<-0x3A then burst_end: bcd_err=1, entry 1 is unchanged, no commit_pulse.
